// File: rtl/fas_pkg.sv
// Shared constants, sample layout and FSM encoding for the FAS peak detector.
// FAS_MAG_ABS_EN selects the |re|+|im| magnitude and narrows MAGW to match.
package fas_pkg;

   localparam int DW   = 16;
   localparam int NBIN = 16;
   localparam int IDXW = $clog2(NBIN);

`ifdef FAS_MAG_ABS_EN
   localparam int MAGW = DW + 1;
`else
   localparam int MAGW = 2*DW + 1;
`endif

   // Bin word layout: real part in the upper half, imaginary part in the lower half.
   typedef struct packed {
      logic signed [DW-1:0] re;
      logic signed [DW-1:0] im;
   } cplx_t;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SCAN   = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;
   localparam logic [1:0] ST_REPORT = 2'd3;

endpackage

// File: rtl/fas_peak_detector_if.sv
// FFT-to-peak-detector bus: frame strobe and bins in, result and status out.
interface fas_peak_detector_if;
   import fas_pkg::*;

   logic                      fft_valid;
   logic [NBIN-1:0][2*DW-1:0] fft_d;
   logic                      done;
   logic [IDXW-1:0]           freq;
   logic                      busy;
   logic                      overrun;

   modport master (output fft_valid, fft_d, input done, freq, busy, overrun);
   modport slave  (input fft_valid, fft_d, output done, freq, busy, overrun);

endinterface

// File: rtl/fas_mag_unit.sv
// Combinational magnitude of one complex sample, registered by the caller.
// FAS_MAG_ABS_EN: |re|+|im| instead of the exact re^2+im^2.
module fas_mag_unit
   import fas_pkg::*;
(
   input  cplx_t           sample,
   output logic [MAGW-1:0] mag
);

`ifdef FAS_MAG_ABS_EN
   logic signed [DW:0] ext_re, ext_im;
   logic        [DW:0] abs_re, abs_im;

   // NOTE: every always_comb output gets a value on every path so no latch is inferred.
   always_comb begin
      ext_re = {sample.re[DW-1], sample.re};
      ext_im = {sample.im[DW-1], sample.im};
      // One extra bit lets -32768 become +32768 without wrapping.
      abs_re = ext_re[DW] ? -ext_re : ext_re;
      abs_im = ext_im[DW] ? -ext_im : ext_im;
      mag    = abs_re + abs_im;
   end
`else
   logic signed [2*DW-1:0] re_sq, im_sq;

   // NOTE: every always_comb output gets a value on every path so no latch is inferred.
   always_comb begin
      re_sq = sample.re * sample.re;
      im_sq = sample.im * sample.im;
      // Squares are non-negative; the carry bit keeps 2^31 exact for two -32768 inputs.
      mag   = {1'b0, re_sq} + {1'b0, im_sq};
   end
`endif

endmodule

// File: rtl/fas_peak_detector.sv
// Captures one FFT frame, scans its bins through a single magnitude unit and
// reports the index of the strongest bin with a one-cycle done pulse.
module fas_peak_detector
   import fas_pkg::*;
#(
   parameter bit SKIP_DC = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   fas_peak_detector_if.slave  bus
);

   logic [1:0]      state;
   cplx_t           frame [NBIN];
   logic [IDXW-1:0] k;
   logic [MAGW-1:0] mag, mag_q, max_mag;
   logic [IDXW-1:0] idx_q, max_idx, freq_q;
   logic            cmp_valid, first, done_q, overrun_q;
   logic            eligible;

   fas_mag_unit u_mag (
      .sample (frame[k]),
      .mag    (mag)
   );

   assign eligible = !(SKIP_DC && idx_q == '0);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_IDLE;
         k         <= '0;
         mag_q     <= '0;
         idx_q     <= '0;
         max_mag   <= '0;
         max_idx   <= '0;
         first     <= 1'b0;
         cmp_valid <= 1'b0;
         done_q    <= 1'b0;
         freq_q    <= '0;
         overrun_q <= 1'b0;
         // NOTE: the frame buffer is plain flops, so it is cleared with the rest of the state.
         for (int i = 0; i < NBIN; i++) frame[i] <= '0;
      end else begin
         done_q    <= 1'b0;
         cmp_valid <= (state == ST_SCAN);

         if (state == ST_SCAN) begin
            mag_q <= mag;
            idx_q <= k;
         end

         if (bus.fft_valid && state != ST_IDLE) overrun_q <= 1'b1;

         // Strict compare keeps the lowest index on ties.
         if (cmp_valid && eligible && (first || mag_q > max_mag)) begin
            max_mag <= mag_q;
            max_idx <= idx_q;
            first   <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (bus.fft_valid) begin
                  for (int i = 0; i < NBIN; i++) frame[i] <= bus.fft_d[i];
                  max_mag <= '0;
                  max_idx <= IDXW'(SKIP_DC);
                  first   <= 1'b1;
                  k       <= '0;
                  state   <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               k <= k + 1'b1;
               if (k == IDXW'(NBIN - 1)) state <= ST_DRAIN;
            end
            ST_DRAIN:  state <= ST_REPORT;
            ST_REPORT: begin
               freq_q <= max_idx;
               done_q <= 1'b1;
               state  <= ST_IDLE;
            end
            default:   state <= ST_IDLE;
         endcase
      end
   end

   // The done cycle counts as busy even though the FSM is already back in IDLE.
   assign bus.busy    = (state != ST_IDLE) || done_q;
   assign bus.done    = done_q;
   assign bus.freq    = freq_q;
   assign bus.overrun = overrun_q;

endmodule
